// File: rtl/instruction_prefetch_pkg.sv
// Shared constants, queue entry layout and fetch FSM states for the rv32i
// instruction prefetch front end.
package instruction_prefetch_pkg;

    localparam int EXCEPTION_LEN = 4;

    localparam logic [31:0]              NOP                    = 32'h0000_0013;
    localparam logic [6:0]               OPCODE_JAL             = 7'b1101111;
    localparam logic [EXCEPTION_LEN-1:0] EXC_NONE               = 4'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXC_INSTR_MISALIGNED   = 4'd1;
    localparam logic [EXCEPTION_LEN-1:0] EXC_INSTR_ACCESS_FAULT = 4'd2;
    localparam logic [1:0]               MEM_WIDTH_WORD         = 2'b10;
    localparam logic [31:0]              BOOT_ADDR              = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DRAIN,
        ST_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]              instr;
        logic [31:0]              pc;
        logic [EXCEPTION_LEN-1:0] exc;
        logic                     pred;
    } queue_entry_t;

    // Sign-extended J-type immediate of a JAL word.
    function automatic logic [31:0] jal_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_prefetch_if.sv
// Instruction-side memory port between the prefetch unit (master) and the
// instruction memory (slave).
interface instruction_prefetch_if;
    import instruction_prefetch_pkg::*;

    logic [31:0]              memAddr_Out;
    logic [31:0]              memData_Out;
    logic [1:0]               memDataWidth_Out;
    logic                     memIsRead_Out;
    logic                     memAccess_Out;
    logic                     memAccessOK_In;
    logic [31:0]              memData_In;
    logic [EXCEPTION_LEN-1:0] memException_In;

    modport master (
        output memAddr_Out, memData_Out, memDataWidth_Out, memIsRead_Out, memAccess_Out,
        input  memAccessOK_In, memData_In, memException_In
    );

    modport slave (
        input  memAddr_Out, memData_Out, memDataWidth_Out, memIsRead_Out, memAccess_Out,
        output memAccessOK_In, memData_In, memException_In
    );

endinterface

// File: rtl/instruction_prefetch_fetch_queue.sv
// Synchronous FIFO holding prefetched entries; head is read from the storage
// registers so nothing combinational reaches the consumer.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop, do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_FULL) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_prefetch.sv
// rv32i fetch front end: sequential prefetch into a DEPTH-entry queue with
// redirect/drain handling. Optional static JAL prediction: FETCH_JAL_PREDICT_EN.
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = BOOT_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_In,
    input  logic [31:0]              redirectPc_In,
    output logic [31:0]              instr_Out,
    output logic [31:0]              instrPc_Out,
    output logic                     instrValid_Out,
    output logic                     instrPredicted_Out,
    output logic [EXCEPTION_LEN-1:0] exception_Out,
    input  logic                     instrIsConsumed_In,
    instruction_prefetch_if.master   mem_if
);
    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   seq_pc, taken_pc;
    logic          take_jal;
    logic          resp_ok;
    logic          q_push, q_pop, q_clear;
    logic [CW-1:0] q_count, count_next;
    queue_entry_t  push_entry, head_entry;

    assign resp_ok = mem_if.memAccessOK_In;
    assign seq_pc  = fetch_pc_q + 32'd4;

`ifdef FETCH_JAL_PREDICT_EN
    logic [31:0] jal_target;
    assign jal_target = fetch_pc_q + jal_imm(mem_if.memData_In);
    assign take_jal   = (mem_if.memData_In[6:0] == OPCODE_JAL) &&
                        (mem_if.memException_In == EXC_NONE) &&
                        (jal_target[1:0] == 2'b00);
    assign taken_pc   = jal_target;
`else
    assign take_jal = 1'b0;
    assign taken_pc = seq_pc;
`endif

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        q_push           = 1'b0;
        q_pop            = 1'b0;
        q_clear          = 1'b0;
        count_next       = q_count;
        push_entry.instr = mem_if.memData_In;
        push_entry.pc    = fetch_pc_q;
        push_entry.exc   = mem_if.memException_In;
        push_entry.pred  = take_jal;

        if (redirect_In) begin
            q_clear    = 1'b1;
            fetch_pc_d = redirectPc_In;
            if ((state_q == ST_BUSY || state_q == ST_DRAIN) && !resp_ok)
                state_d = ST_DRAIN;
            else if (redirectPc_In[1:0] == 2'b00)
                state_d = ST_BUSY;
            else
                state_d = ST_IDLE;
        end else begin
            q_pop = instrIsConsumed_In;
            unique case (state_q)
                ST_IDLE: begin
                    // Only a redirect can leave fetch_pc misaligned; report it in place of a fetch.
                    if (fetch_pc_q[1:0] != 2'b00) begin
                        q_push           = 1'b1;
                        push_entry.instr = NOP;
                        push_entry.exc   = EXC_INSTR_MISALIGNED;
                        push_entry.pred  = 1'b0;
                        state_d          = ST_HALT;
                    end
                end
                ST_BUSY: begin
                    if (resp_ok) begin
                        q_push = 1'b1;
                        if (mem_if.memException_In != EXC_NONE) begin
                            state_d = ST_HALT;
                        end else begin
                            fetch_pc_d = take_jal ? taken_pc : seq_pc;
                            state_d    = ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (resp_ok) state_d = ST_IDLE;
                end
                ST_HALT: ;
                default: state_d = ST_IDLE;
            endcase

            count_next = q_count + CW'(q_push) - CW'(q_pop && (q_count != '0));
            // Issue straight away when the response is sure to find a free slot.
            if (state_d == ST_IDLE && fetch_pc_d[1:0] == 2'b00 && count_next < CNT_FULL)
                state_d = ST_BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(queue_entry_t))
    ) u_fetch_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (q_push),
        .push_data_i (push_entry),
        .pop_i       (q_pop),
        .clear_i     (q_clear),
        .count_o     (q_count),
        .head_o      (head_entry)
    );

    assign instrValid_Out     = (q_count != '0);
    assign instr_Out          = instrValid_Out ? head_entry.instr : NOP;
    assign instrPc_Out        = instrValid_Out ? head_entry.pc    : 32'h0;
    assign exception_Out      = instrValid_Out ? head_entry.exc   : EXC_NONE;
    assign instrPredicted_Out = instrValid_Out && head_entry.pred;

    assign mem_if.memAddr_Out      = fetch_pc_q;
    assign mem_if.memData_Out      = 32'h0;
    assign mem_if.memDataWidth_Out = MEM_WIDTH_WORD;
    assign mem_if.memIsRead_Out    = 1'b1;
    assign mem_if.memAccess_Out    = (state_q == ST_BUSY || state_q == ST_DRAIN) && !resp_ok;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Randomised bench for instruction_prefetch: a queue-level reference model
// plus a behavioural instruction memory, with directed scenarios up front.
module tb_instruction_prefetch;
    import instruction_prefetch_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0]              instr;
        logic [31:0]              pc;
        logic [EXCEPTION_LEN-1:0] exc;
        logic                     pred;
    } ent_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     redirect_In = 1'b0;
    logic [31:0]              redirectPc_In = 32'h0;
    logic                     instrIsConsumed_In = 1'b0;
    logic [31:0]              instr_Out, instrPc_Out;
    logic                     instrValid_Out, instrPredicted_Out;
    logic [EXCEPTION_LEN-1:0] exception_Out;

    instruction_prefetch_if mif ();

    instruction_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk                (clk),
        .rst                (rst),
        .redirect_In        (redirect_In),
        .redirectPc_In      (redirectPc_In),
        .instr_Out          (instr_Out),
        .instrPc_Out        (instrPc_Out),
        .instrValid_Out     (instrValid_Out),
        .instrPredicted_Out (instrPredicted_Out),
        .exception_Out      (exception_Out),
        .instrIsConsumed_In (instrIsConsumed_In),
        .mem_if             (mif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    ent_t        mq[$];
    logic [31:0] exp_pc = 32'h0;
    bit          halted = 0, live = 0, mis_pending = 0;
    logic [31:0] mis_pc = 32'h0;
    int          mis_timer = 0;
    int          pops = 0;

    // behavioural memory
    bit          mem_pending = 0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt = 0;
    int          lat_cfg = 1;
    bit          rand_mode = 0, fault_en = 0, jal_en = 0;
    logic [31:0] fault_addr = 32'h0, jal_addr = 32'h0, jal_word = 32'h0;
    logic [31:0] cap_log[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int i);
        return (i < cap_log.size()) ? cap_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic step(input bit redir, input logic [31:0] rpc, input bit cons);
        bit                       ok;
        logic [31:0]              d, tgt;
        logic [EXCEPTION_LEN-1:0] e;
        ent_t                     got, exp_h;
        bit                       pred;
        @(posedge clk);
        #1;
        ok = mem_pending && (mem_cnt == 0);
        d  = 32'h0;
        e  = '0;
        if (ok) begin
            if (rand_mode) begin
                d = $urandom;
                if ($urandom_range(0, 3) == 0) d[6:0] = 7'b1101111;
                if ($urandom_range(0, 39) == 0) e = EXC_INSTR_ACCESS_FAULT;
            end else begin
                d = (jal_en && mem_addr == jal_addr) ? jal_word : mem_addr;
                e = (fault_en && mem_addr == fault_addr) ? EXC_INSTR_ACCESS_FAULT : EXC_NONE;
            end
        end
        mif.memAccessOK_In  = ok;
        mif.memData_In      = d;
        mif.memException_In = e;
        redirect_In         = redir;
        redirectPc_In       = rpc;
        instrIsConsumed_In  = cons;
        #1;

        got = {instr_Out, instrPc_Out, exception_Out, instrPredicted_Out};
        if (mq.size() == 0 && mis_pending && instrValid_Out) begin
            exp_h = {NOP, mis_pc, EXC_INSTR_MISALIGNED, 1'b0};
            chk("misaligned_entry", got, exp_h);
            mq.push_back(exp_h);
            mis_pending = 0;
            halted      = 1;
        end else begin
            chk("valid", instrValid_Out, mq.size() != 0);
            if (mq.size() != 0) chk("head", got, mq[0]);
            else                chk("empty_head", got, {NOP, 32'h0, EXC_NONE, 1'b0});
        end

        if (ok) begin
            chk("access_drop_on_ok", mif.memAccess_Out, 1'b0);
            mem_pending = 0;
        end else if (mem_pending) begin
            chk("access_held", mif.memAccess_Out, 1'b1);
            mem_cnt--;
        end else if (mif.memAccess_Out) begin
            cap_log.push_back(mif.memAddr_Out);
            chk("req_addr", mif.memAddr_Out, exp_pc);
            chk("req_allowed", {halted, mis_pending, mq.size() < DEPTH}, 3'b001);
            mem_pending = 1;
            mem_addr    = mif.memAddr_Out;
            mem_cnt     = ((lat_cfg == 0) ? $urandom_range(1, 3) : lat_cfg) - 1;
            live        = 1;
        end

        if (redir) begin
            mq.delete();
            exp_pc      = rpc;
            live        = 0;
            halted      = 0;
            mis_pending = (rpc[1:0] != 2'b00);
            mis_pc      = rpc;
            mis_timer   = 0;
        end else begin
            if (cons && mq.size() != 0) begin
                void'(mq.pop_front());
                pops++;
            end
            if (ok && live) begin
                pred = 0;
                tgt  = exp_pc + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
                if (e == EXC_NONE && d[6:0] == 7'b1101111) begin
                    tgt = exp_pc + {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
                    if (tgt[1:0] == 2'b00) pred = 1;
                    else                   tgt  = exp_pc + 32'd4;
                end
`endif
                mq.push_back({d, exp_pc, e, pred});
                if (e != EXC_NONE) halted = 1;
                else               exp_pc = tgt;
                live = 0;
            end
            if (mis_pending && !mem_pending) begin
                mis_timer++;
                if (mis_timer > 3) begin
                    checks++;
                    errors++;
                    $display("FAIL misaligned_timeout: no entry for pc %h, required within 3 cycles", mis_pc);
                    mis_pending = 0;
                end
            end
        end
    endtask

    initial begin
        int n0, p0;
        logic [31:0] rpc;
        mif.memAccessOK_In  = 1'b0;
        mif.memData_In      = 32'h0;
        mif.memException_In = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", instrValid_Out, 1'b0);
        chk("rst_instr", instr_Out, NOP);
        chk("rst_pc", instrPc_Out, 32'h0);
        chk("rst_exc", exception_Out, EXC_NONE);
        chk("rst_pred", instrPredicted_Out, 1'b0);
        chk("rst_access", mif.memAccess_Out, 1'b0);
        chk("const_read", mif.memIsRead_Out, 1'b1);
        chk("const_width", mif.memDataWidth_Out, MEM_WIDTH_WORD);
        chk("const_wdata", mif.memData_Out, 32'h0);
        rst = 1'b1;

        // fill with a 1-cycle memory, never consume
        lat_cfg = 1;
        repeat (20) step(0, 32'h0, 0);
        chk("fill_req_count", cap_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("fill_req_addr", cap_at(i), 32'(i * 4));
        chk("full_no_access", mif.memAccess_Out, 1'b0);
        chk("full_head_pc", instrPc_Out, 32'h0);

        // consume one per cycle
        p0 = pops;
        repeat (16) step(0, 32'h0, 1);
        chk("drain_progress", (pops - p0) >= 8, 1'b1);
        for (int i = 0; i < cap_log.size(); i++) chk("contig_addr", cap_log[i], 32'(i * 4));

        // redirect to 0x100 while an access is outstanding
        lat_cfg = 2;
        for (int i = 0; i < 20 && !(mem_pending && mem_cnt > 0); i++) step(0, 32'h0, 1);
        chk("busy_reached", mem_pending && mem_cnt > 0, 1'b1);
        n0 = cap_log.size();
        step(1, 32'h100, 0);
        repeat (8) step(0, 32'h0, 0);
        chk("redirect_req", cap_at(n0), 32'h100);
        chk("redirect_head", instrPc_Out, 32'h100);

        // access fault at 0x8 halts fetching
        lat_cfg    = 1;
        fault_en   = 1;
        fault_addr = 32'h8;
        step(1, 32'h0, 0);
        n0 = cap_log.size();
        repeat (15) step(0, 32'h0, 0);
        chk("fault_req_count", cap_log.size() - n0, 3);
        chk("fault_req2", cap_at(n0 + 2), 32'h8);
        step(0, 32'h0, 1);
        step(0, 32'h0, 1);
        step(0, 32'h0, 0);
        chk("fault_head_pc", instrPc_Out, 32'h8);
        chk("fault_head_exc", exception_Out, EXC_INSTR_ACCESS_FAULT);
        repeat (5) step(0, 32'h0, 0);
        chk("halt_no_req", cap_log.size() - n0, 3);
        fault_en = 0;

        // misaligned redirect
        step(1, 32'h102, 0);
        n0 = cap_log.size();
        repeat (6) step(0, 32'h0, 0);
        chk("mis_valid", instrValid_Out, 1'b1);
        chk("mis_pc", instrPc_Out, 32'h102);
        chk("mis_exc", exception_Out, EXC_INSTR_MISALIGNED);
        chk("mis_instr", instr_Out, NOP);
        chk("mis_no_req", cap_log.size(), n0);

        // JAL at 0x0
        jal_en   = 1;
        jal_addr = 32'h0;
        jal_word = 32'h0100_006F;
        step(1, 32'h0, 0);
        n0 = cap_log.size();
        step(0, 32'h0, 0);
        chk("redir_next_cycle_req", cap_log.size(), n0 + 1);
        chk("redir_next_cycle_addr", cap_at(n0), 32'h0);
        repeat (8) step(0, 32'h0, 0);
        chk("jal_head_instr", instr_Out, 32'h0100_006F);
`ifdef FETCH_JAL_PREDICT_EN
        chk("jal_next_req", cap_at(n0 + 1), 32'h10);
        chk("jal_pred", instrPredicted_Out, 1'b1);
`else
        chk("jal_next_req", cap_at(n0 + 1), 32'h4);
        chk("jal_pred", instrPredicted_Out, 1'b0);
`endif
        jal_en = 0;

        // randomised traffic
        rand_mode = 1;
        lat_cfg   = 0;
        p0        = pops;
        for (int i = 0; i < 3000; i++) begin
            rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 1) == 1);
        end
        chk("random_progress", (pops - p0) > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
# instruction_prefetch

Parametrised instruction-fetch front end for the rv32i core. It decouples instruction memory from the backend with a DEPTH-entry prefetch queue, fetching sequentially ahead of the backend. It supports backend redirects with discard of in-flight data and optional static JAL target prediction. It sits between the instruction-side memory port and the decode stage.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, `BOOT_ADDR, fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- redirect_In  in  1  flush queue and restart fetch at redirectPc_In
- redirectPc_In  in  32  new fetch address
- instr_Out  out  32  head-entry instruction; NOP when queue empty
- instrPc_Out  out  32  address of head entry
- instrValid_Out  out  1  queue non-empty
- instrPredicted_Out  out  1  head entry was a predicted-taken JAL
- exception_Out  out  `EXCEPTION_LEN  head-entry exception; 0 when empty
- instrIsConsumed_In  in  1  pop head entry when instrValid_Out is high
- memAddr_Out  out  32  fetch address
- memData_Out  out  32  constant 0
- memDataWidth_Out  out  2  constant `MEM_WIDTH_WORD
- memIsRead_Out  out  1  constant 1
- memAccess_Out  out  1  request strobe
- memAccessOK_In  in  1  response valid, one-cycle pulse
- memData_In  in  32  fetched word
- memException_In  in  `EXCEPTION_LEN  access fault, valid with memAccessOK_In

## Operation
- Fetch FSM states: IDLE (no access outstanding), BUSY (access outstanding, keep data), DRAIN (access outstanding, discard data), HALT (exception queued, no fetch).
- IDLE→BUSY: when count + 0 < DEPTH. Requests are issued only if the response has a guaranteed free slot. memAccess_Out is high in BUSY/DRAIN and deasserts combinationally in the cycle memAccessOK_In is high.
- BUSY + OK: push {memData_In, fetch_pc, memException_In, pred}. If the exception is non-zero, go to HALT. Otherwise fetch_pc ← next PC and go to IDLE.
- Next PC is fetch_pc + 4, modulo 2^32 (wraps at 0xFFFF_FFFC → 0).
- DRAIN + OK: discard data, go to IDLE with the already-updated fetch_pc.
- Redirect (any state):
  - clear the queue;
  - fetch_pc ← redirectPc_In;
  - BUSY→DRAIN, DRAIN stays DRAIN, IDLE/HALT→IDLE.
- Redirect with OK in the same cycle: discard data, go to IDLE.
- Redirect with consume in the same cycle: redirect wins, the pop is ignored.
- Misaligned redirect (redirectPc_In[1:0] ≠ 0): after any drain completes, push an entry with instr NOP, pc = redirectPc_In, exception = `EXC_INSTR_MISALIGNED; go to HALT with no memory access.
- Pop and push in the same cycle are both honoured. Count never exceeds DEPTH; pop on an empty queue is ignored.

## Timing
- Reset values:
  - queue empty, state IDLE, fetch_pc = RESET_PC;
  - instrValid_Out 0, instr_Out NOP, instrPc_Out 0, exception_Out 0, instrPredicted_Out 0, memAccess_Out 0.
- First memAccess_Out occurs in the first cycle after rst deasserts.
- memAccessOK_In must arrive ≥1 cycle after memAccess_Out rises; the memory response is registered.
- OK at cycle M → instrValid_Out at M+1. Next request is at M+1 at the earliest, giving 2 cycles/instruction with a 1-cycle memory.
- Redirect at cycle N with no access outstanding → memAddr_Out = redirectPc_In with memAccess_Out high at N+1.
- Queue outputs are driven from registers only; there is no combinational path from mem* or redirect_In to instr*.

## Configuration
- FETCH_JAL_PREDICT_EN defined: on a BUSY+OK push with no exception and memData_In[6:0] = 7'b1101111:
  - target = fetch_pc + sign-extended J-immediate;
  - if target[1:0] = 0: next fetch_pc ← target, entry pred = 1;
  - otherwise sequential, pred = 0.
- Undefined: always sequential; instrPredicted_Out tied to 0; no J-immediate adder is synthesised.

## Structure
- constants.v holds NOP, OPCODE_JAL, EXC_INSTR_MISALIGNED, MEM_WIDTH_WORD, BOOT_ADDR and EXCEPTION_LEN.
- Sub-module fetch_queue: synchronous FIFO with parameters DEPTH and WIDTH (32+32+EXCEPTION_LEN+1). It provides push, pop, clear, count, and a registered head.
- FSM and PC logic live in instruction_prefetch.

## Test plan
- Reset, 1-cycle memory returning word = address, never consume:
  - requests to RESET_PC, +4, +8, +0xC;
  - then memAccess_Out stays low with count = 4.
- Full queue, consume one per cycle: exactly one new request per freed slot; instrPc_Out sequence is contiguous, with no drop or duplicate.
- Redirect to 0x100 while BUSY:
  - the in-flight response is discarded;
  - the next request is at 0x100;
  - the queue is empty during the drain.
- memException_In = fault at 0x8: entry with exception, then no further memAccess_Out until a redirect.
- Redirect to 0x102: a single entry pc = 0x102, exception misaligned, and no memory access.
- FETCH_JAL_PREDICT_EN defined, word 0x0100006F (jal x0, +16) at 0x0:
  - next request at 0x10;
  - instrPredicted_Out = 1 for that entry.
